// File: rtl/reg_commit_arbiter.sv
// reg_commit_arbiter
//   Two requesters (req0 = SPI side, req1 = internal engine) post register
//   writes into a small in-order queue. The queue drains one entry per cycle
//   while vblank is high, so visible registers only change inside the
//   blanking window.
//
// Ports
//   clk, reset_n                 clock (rising edge), async active-low reset
//   reqN_valid/addr/data/ready   write request handshake, N = 0,1
//                                addr 1-4 -> color1-4, 7 -> misc, else dropped
//   vblank                       commit window
//   color1..color4, misc         committed registers
//   pending                      queue non-empty
//   commit                       pulse, cycle after a register update
//   drop                         pulse, cycle after an invalid entry is popped
//
// Build option
//   ROUND_ROBIN_EN  defined: round-robin arbitration on contention
//                   undefined: fixed priority, req0 wins
module reg_commit_arbiter #(
    parameter logic [5:0] COLOR1_DEFAULT = 6'h00,
    parameter logic [5:0] COLOR2_DEFAULT = 6'h15,
    parameter logic [5:0] COLOR3_DEFAULT = 6'h2A,
    parameter logic [5:0] COLOR4_DEFAULT = 6'h3F,
    parameter logic [4:0] MISC_DEFAULT   = 5'h00,
    parameter int         FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req0_valid,
    input  logic [2:0] req0_addr,
    input  logic [5:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [2:0] req1_addr,
    input  logic [5:0] req1_data,
    output logic       req1_ready,
    input  logic       vblank,
    output logic [5:0] color1,
    output logic [5:0] color2,
    output logic [5:0] color3,
    output logic [5:0] color4,
    output logic [4:0] misc,
    output logic       pending,
    output logic       commit,
    output logic       drop
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [2:0] addr;
        logic [5:0] data;
    } entry_t;

    entry_t        mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          has_room, grant0, grant1, push, pop;
    entry_t        push_entry, pop_entry;

    // Room is judged on the current count only: a pop in the same cycle
    // does not free a slot for a push into a full queue.
    assign has_room = count < (PW+1)'(FIFO_DEPTH);

`ifdef ROUND_ROBIN_EN
    // prio names the requester that wins the next contention; it flips to
    // the other requester after every grant.
    logic prio;
    assign grant0 = req0_valid && (!req1_valid || !prio);
    assign grant1 = req1_valid && (!req0_valid ||  prio);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)        prio <= 1'b0;
        else if (req0_ready) prio <= 1'b1;
        else if (req1_ready) prio <= 1'b0;
    end
`else
    assign grant0 = req0_valid;
    assign grant1 = req1_valid && !req0_valid;
`endif

    assign req0_ready = reset_n && has_room && grant0;
    assign req1_ready = reset_n && has_room && grant1;

    assign push       = req0_ready || req1_ready;
    assign push_entry = req0_ready ? {req0_addr, req0_data} : {req1_addr, req1_data};
    assign pop        = vblank && (count != '0);
    assign pop_entry  = mem[rd_ptr];
    assign pending    = (count != '0);

    // Pointers are PW bits wide, so they wrap modulo FIFO_DEPTH for free.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            color1 <= COLOR1_DEFAULT;
            color2 <= COLOR2_DEFAULT;
            color3 <= COLOR3_DEFAULT;
            color4 <= COLOR4_DEFAULT;
            misc   <= MISC_DEFAULT;
            commit <= 1'b0;
            drop   <= 1'b0;
        end else begin
            commit <= 1'b0;
            drop   <= 1'b0;
            if (pop) begin
                case (pop_entry.addr)
                    3'd1: begin color1 <= pop_entry.data;      commit <= 1'b1; end
                    3'd2: begin color2 <= pop_entry.data;      commit <= 1'b1; end
                    3'd3: begin color3 <= pop_entry.data;      commit <= 1'b1; end
                    3'd4: begin color4 <= pop_entry.data;      commit <= 1'b1; end
                    3'd7: begin misc   <= pop_entry.data[4:0]; commit <= 1'b1; end
                    default: drop <= 1'b1;
                endcase
            end
        end
    end
endmodule
